// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer : RV32 multicycle control FSM (fetch handshake, ALU
//                        decode, writeback strobes, retire count, traps)
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [31:0]          instr,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 regwrite,
  output logic [2:0]           alucontrol,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic [CNT_W-1:0]       tcnt_q, tcnt_d;
  logic [2:0]             alu_q, alu_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [1:0]             fcode_q, fcode_d;

  logic [CNT_W-1:0]       tcnt_inc;
  logic                   dec_legal;
  logic [2:0]             dec_alu;

  // rs1/rs2/immediate fields belong to the datapath, not to this controller.
  logic                   ir_unused;
  assign ir_unused = ^ir_q[24:15];

  assign tcnt_inc = tcnt_q + CNT_W'(1);

  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = ALU_ADD;
    if (ir_q[6:0] == OPC_OP) begin
      if (ir_q[31:25] == 7'b0000000) begin
        dec_legal = 1'b1;
        case (ir_q[14:12])
          3'b000:  dec_alu = ALU_ADD;
          3'b111:  dec_alu = ALU_AND;
          3'b110:  dec_alu = ALU_OR;
          3'b010:  dec_alu = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end else if (ir_q[31:25] == 7'b0100000 && ir_q[14:12] == 3'b000) begin
        dec_legal = 1'b1;
        dec_alu   = ALU_SUB;
      end
    end else if (ir_q[6:0] == OPC_OP_IMM) begin
      dec_legal = 1'b1;
      case (ir_q[14:12])
        3'b000:  dec_alu = ALU_ADD;
        3'b111:  dec_alu = ALU_AND;
        3'b110:  dec_alu = ALU_OR;
        3'b010:  dec_alu = ALU_SLT;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tcnt_d    = tcnt_q;
    alu_d     = alu_q;
    instret_d = instret_q;
    fcode_d   = fcode_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          tcnt_d  = '0;
        end
      end
      S_FETCH: begin
        // An ack in the expiring cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          tcnt_d = tcnt_inc;
          if (TIMEOUT_EN && tcnt_inc == TIMEOUT_VAL) begin
            state_d = S_FAULT;
            fcode_d = FC_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          alu_d   = dec_alu;
          state_d = S_EXECUTE;
        end else begin
          state_d = S_FAULT;
          fcode_d = FC_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        instret_d = instret_q + INSTRET_W'(1);
        if (run) begin
          state_d = S_FETCH;
          tcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      tcnt_q    <= '0;
      alu_q     <= '0;
      instret_q <= '0;
      fcode_q   <= FC_NONE;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tcnt_q    <= tcnt_d;
      alu_q     <= alu_d;
      instret_q <= instret_d;
      fcode_q   <= fcode_d;
    end
  end

  // Strobes come straight from the state register; only ir_we sees an input.
  assign imem_req   = (state_q == S_FETCH);
  assign ir_we      = (state_q == S_FETCH) && imem_ack;
  assign pc_we      = (state_q == S_WRITEBACK);
  assign retire     = (state_q == S_WRITEBACK);
  assign regwrite   = (state_q == S_WRITEBACK) && (ir_q[11:7] != 5'd0);
  assign alucontrol = alu_q;
  assign instret    = instret_q;
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fcode_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer : vector table, directed corner sequences and a
//                           randomized run against a transaction-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          imem_req;
  logic          imem_ack;
  logic [31:0]   instr;
  logic          ir_we;
  logic          pc_we;
  logic          regwrite;
  logic [2:0]    alucontrol;
  logic          retire;
  logic [IW-1:0] instret;
  logic          fault;
  logic [1:0]    fault_code;

  int checks   = 0;
  int failures = 0;

  multicycle_sequencer #(.TIMEOUT_CYCLES(TO), .INSTRET_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .retire     (retire),
    .instret    (instret),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        legal;
    logic [2:0]  alu;
    logic        rw;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req"},     32'(imem_req),   32'd0);
    chk({pfx, "_irwe"},    32'(ir_we),      32'd0);
    chk({pfx, "_pcwe"},    32'(pc_we),      32'd0);
    chk({pfx, "_regw"},    32'(regwrite),   32'd0);
    chk({pfx, "_alu"},     32'(alucontrol), 32'd0);
    chk({pfx, "_retire"},  32'(retire),     32'd0);
    chk({pfx, "_instret"}, 32'(instret),    32'd0);
    chk({pfx, "_fault"},   32'(fault),      32'd0);
    chk({pfx, "_fcode"},   32'(fault_code), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    instr    = 32'd0;
    #1;
    chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    reset = 1'b1;
  endtask

  // Entered in a FETCH cycle; leaves just after the edge following WRITEBACK.
  task automatic exec_ok(input logic [31:0] w, input logic [2:0] alu, input logic rw, input string nm);
    imem_ack = 1'b1;
    instr    = w;
    #1;
    chk({nm, "_req"},  32'(imem_req), 32'd1);
    chk({nm, "_irwe"}, 32'(ir_we),    32'd1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk({nm, "_dec_req"},    32'(imem_req), 32'd0);
    chk({nm, "_dec_retire"}, 32'(retire),   32'd0);
    tick();
    #1;
    chk({nm, "_ex_retire"}, 32'(retire), 32'd0);
    tick();
    #1;
    chk({nm, "_wb_retire"}, 32'(retire),     32'd1);
    chk({nm, "_wb_pcwe"},   32'(pc_we),      32'd1);
    chk({nm, "_wb_regw"},   32'(regwrite),   32'(rw));
    chk({nm, "_wb_alu"},    32'(alucontrol), 32'(alu));
    tick();
  endtask

  // Spec-level decode: returns {legal, alucontrol}.
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (op == 7'b0110011) begin
      if (f7 == 7'h00 && f3 == 3'd0) return {1'b1, 3'b010};
      if (f7 == 7'h20 && f3 == 3'd0) return {1'b1, 3'b110};
      if (f7 == 7'h00 && f3 == 3'd7) return {1'b1, 3'b000};
      if (f7 == 7'h00 && f3 == 3'd6) return {1'b1, 3'b001};
      if (f7 == 7'h00 && f3 == 3'd2) return {1'b1, 3'b111};
      return 4'b0000;
    end
    if (op == 7'b0010011) begin
      if (f3 == 3'd0) return {1'b1, 3'b010};
      if (f3 == 3'd7) return {1'b1, 3'b000};
      if (f3 == 3'd6) return {1'b1, 3'b001};
      if (f3 == 3'd2) return {1'b1, 3'b111};
    end
    return 4'b0000;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int s = $urandom_range(0, 7);
    if (s < 3)      w[6:0] = 7'b0110011;
    else if (s < 6) w[6:0] = 7'b0010011;
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Model state: time since accepted ack, waiting time in fetch, trap status.
  bit          m_fetching;
  int          m_k;
  int          m_wait;
  bit          m_faulted;
  int          m_fault_age;
  logic [1:0]  m_code;
  logic [2:0]  m_alu;
  int          m_instret;
  logic [31:0] m_cur;

  task automatic model_reset();
    m_fetching  = 1'b0;
    m_k         = -1;
    m_wait      = 0;
    m_faulted   = 1'b0;
    m_fault_age = 0;
    m_code      = 2'b00;
    m_alu       = 3'b000;
    m_instret   = 0;
    m_cur       = 32'd0;
  endtask

  task automatic model_step();
    logic [3:0] d;
    if (m_faulted) begin
      m_fault_age++;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_cur      = instr;
        m_k        = 1;
        m_fetching = 1'b0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_faulted   = 1'b1;
          m_fault_age = 0;
          m_code      = 2'b10;
          m_fetching  = 1'b0;
        end
      end
    end else if (m_k == 1) begin
      d = ref_decode(m_cur);
      if (!d[3]) begin
        m_faulted   = 1'b1;
        m_fault_age = 0;
        m_code      = 2'b01;
        m_k         = -1;
      end else begin
        m_alu = d[2:0];
        m_k   = 2;
      end
    end else if (m_k == 2) begin
      m_k = 3;
    end else if (m_k == 3) begin
      m_instret = (m_instret + 1) % (1 << IW);
      m_k       = -1;
      if (run) begin
        m_fetching = 1'b1;
        m_wait     = 0;
      end
    end else if (run) begin
      m_fetching = 1'b1;
      m_wait     = 0;
    end
  endtask

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    instr    = 32'd0;

    vecs[0]  = '{32'h003100B3, 1'b1, 3'b010, 1'b1, "v_add"};
    vecs[1]  = '{32'h403100B3, 1'b1, 3'b110, 1'b1, "v_sub"};
    vecs[2]  = '{32'h0020F093, 1'b1, 3'b000, 1'b1, "v_andi"};
    vecs[3]  = '{32'h00312033, 1'b1, 3'b111, 1'b0, "v_slt_x0"};
    vecs[4]  = '{32'h00310033, 1'b1, 3'b010, 1'b0, "v_add_x0"};
    vecs[5]  = '{32'h0031E0B3, 1'b1, 3'b001, 1'b1, "v_or"};
    vecs[6]  = '{32'h0FF16093, 1'b1, 3'b001, 1'b1, "v_ori_f7"};
    vecs[7]  = '{32'hFFF12093, 1'b1, 3'b111, 1'b1, "v_slti"};
    vecs[8]  = '{32'h0000006F, 1'b0, 3'b000, 1'b0, "v_jal"};
    vecs[9]  = '{32'h023100B3, 1'b0, 3'b000, 1'b0, "v_op_badf7"};
    vecs[10] = '{32'h4031F0B3, 1'b0, 3'b000, 1'b0, "v_and_f7sub"};
    vecs[11] = '{32'h00109093, 1'b0, 3'b000, 1'b0, "v_slli"};
    vecs[12] = '{32'h0031C0B3, 1'b0, 3'b000, 1'b0, "v_xor"};

    // Vector table: one instruction after a fresh reset each.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      run = 1'b1;
      tick();
      imem_ack = 1'b1;
      instr    = vecs[i].w;
      #1;
      chk({vecs[i].name, "_irwe"}, 32'(ir_we), 32'd1);
      tick();
      imem_ack = 1'b0;
      tick();
      #1;
      chk({vecs[i].name, "_fault"}, 32'(fault), 32'(!vecs[i].legal));
      chk({vecs[i].name, "_fcode"}, 32'(fault_code), vecs[i].legal ? 32'd0 : 32'd1);
      tick();
      #1;
      chk({vecs[i].name, "_retire"}, 32'(retire), 32'(vecs[i].legal));
      chk({vecs[i].name, "_regw"}, 32'(regwrite), 32'(vecs[i].legal & vecs[i].rw));
      chk({vecs[i].name, "_alu"}, 32'(alucontrol), vecs[i].legal ? 32'(vecs[i].alu) : 32'd0);
    end

    // Back-to-back retirements, then an illegal trap that must hold.
    do_reset();
    run = 1'b1;
    tick();
    exec_ok(32'h003100B3, 3'b010, 1'b1, "b2b_add");
    #1;
    chk("b2b_instret1", 32'(instret), 32'd1);
    exec_ok(32'h403100B3, 3'b110, 1'b1, "b2b_sub");
    exec_ok(32'h0020F093, 3'b000, 1'b1, "b2b_andi");
    exec_ok(32'h00312033, 3'b111, 1'b0, "b2b_slt");
    #1;
    chk("b2b_instret4", 32'(instret), 32'd4);
    chk("b2b_refetch", 32'(imem_req), 32'd1);
    exec_ok(32'h00310033, 3'b010, 1'b0, "b2b_addx0");
    imem_ack = 1'b1;
    instr    = 32'h0000006F;
    tick();
    imem_ack = 1'b0;
    tick();
    #1;
    chk("jal_fault", 32'(fault), 32'd1);
    chk("jal_fcode", 32'(fault_code), 32'd1);
    chk("jal_alu_kept", 32'(alucontrol), 32'd2);
    chk("jal_instret", 32'(instret), 32'd5);
    for (int c = 0; c < 20; c++) begin
      tick();
      imem_ack = 1'($urandom);
      #1;
      chk("hold_fault", 32'(fault), 32'd1);
      chk("hold_fcode", 32'(fault_code), 32'd1);
      chk("hold_quiet", 32'({imem_req, ir_we, pc_we, regwrite, retire}), 32'd0);
      chk("hold_instret", 32'(instret), 32'd5);
    end

    // Fetch timeout after TO cycles with no ack.
    do_reset();
    run = 1'b1;
    tick();
    for (int c = 0; c < TO; c++) begin
      imem_ack = 1'b0;
      #1;
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_nofault", 32'(fault), 32'd0);
      tick();
    end
    #1;
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_fcode", 32'(fault_code), 32'd2);
    chk("to_req_off", 32'(imem_req), 32'd0);

    // Ack in the last allowed fetch cycle beats the timeout.
    do_reset();
    run = 1'b1;
    tick();
    for (int c = 0; c < TO - 1; c++) begin
      imem_ack = 1'b0;
      tick();
    end
    imem_ack = 1'b1;
    instr    = 32'h003100B3;
    #1;
    chk("late_irwe", 32'(ir_we), 32'd1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("late_nofault", 32'(fault), 32'd0);
    chk("late_req", 32'(imem_req), 32'd0);
    tick();
    tick();
    #1;
    chk("late_retire", 32'(retire), 32'd1);

    // run dropped during EXECUTE: retire, then park in IDLE.
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1;
    instr    = 32'h0031E0B3;
    tick();
    imem_ack = 1'b0;
    tick();
    run = 1'b0;
    tick();
    #1;
    chk("drop_retire", 32'(retire), 32'd1);
    chk("drop_alu", 32'(alucontrol), 32'd1);
    tick();
    #1;
    chk("drop_idle_req", 32'(imem_req), 32'd0);
    chk("drop_instret", 32'(instret), 32'd1);
    imem_ack = 1'b1;
    tick();
    #1;
    chk("drop_ack_ignored", 32'({imem_req, ir_we}), 32'd0);
    imem_ack = 1'b0;

    // Reset asserted during DECODE aborts immediately.
    run = 1'b1;
    tick();
    imem_ack = 1'b1;
    instr    = 32'h403100B3;
    tick();
    imem_ack = 1'b0;
    reset    = 1'b0;
    #1;
    chk_zero("dec_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("dec_rst_noretire", 32'({retire, instret}), 32'd0);

    // Randomized run against the transaction-level model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      run      = ($urandom_range(0, 9) != 0);
      imem_ack = ($urandom_range(0, 4) < 3);
      instr    = gen_instr();
      if (m_faulted && m_fault_age >= 3) begin
        reset = 1'b0;
        #1;
        chk_zero("rnd_rst");
        reset = 1'b1;
        model_reset();
      end else begin
        #1;
        chk("rnd_req",     32'(imem_req),   32'(m_fetching));
        chk("rnd_irwe",    32'(ir_we),      32'(m_fetching && imem_ack));
        chk("rnd_retire",  32'(retire),     32'(m_k == 3));
        chk("rnd_pcwe",    32'(pc_we),      32'(m_k == 3));
        chk("rnd_regw",    32'(regwrite),   32'(m_k == 3 && m_cur[11:7] != 5'd0));
        chk("rnd_alu",     32'(alucontrol), 32'(m_alu));
        chk("rnd_instret", 32'(instret),    32'(m_instret));
        chk("rnd_fault",   32'(fault),      32'(m_faulted));
        chk("rnd_fcode",   32'(fault_code), 32'(m_code));
      end
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
